uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop line synchronizer and a first-word fall-through receive FIFO.
// Latency: a received byte is visible on rdata/data_valid one cycle after its stop-bit sample edge.
// Backpressure: none on the serial line; a byte arriving while the FIFO is full is dropped and flagged by overrun.
module uart_receiver #(
   parameter int CLK_FREQ_HZ = 10000000,
   parameter int BAUD_RATE   = 1000000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxd,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rdata,
   output logic       data_valid,
   output logic       overrun,
   output logic       frame_error
);

   localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
   localparam int HALF = CPB / 2;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_MID   = CW'(HALF - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            rx_meta;
   logic            rx_sync;
   logic            rx_prev;
   logic            fall;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            cnt_clr;
   logic            shift_en;
   logic            push_req;
   logic            ferr_set;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [AW:0]     count;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   // Synchronize the asynchronous line and keep one extra stage for falling-edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev & ~rx_sync;

   // Frame state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle control strobes for the frame parser.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      push_req  = 1'b0;
      ferr_set  = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
               cnt_clr   = 1'b1;
            end
         end
         START: begin
            // Mid-start-bit check: a line that has already gone high was a glitch.
            if (cnt == CNT_MID) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_clr = 1'b1;
               if (rx_sync) begin
                  push_req  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_set  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            // Hold off edge detection until the line has returned to idle.
            if (rx_sync) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Baud counter, bit counter and LSB-first shift register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         bit_cnt <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         if (cnt_clr || state == IDLE || state == BREAK) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (state == IDLE) begin
            bit_cnt <= 3'd0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (shift_en) begin
            shreg <= {rx_sync, shreg[7:1]};
         end
      end
   end

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign pop   = rd_en & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
   assign push  = push_req & (~full | pop);

   // FIFO storage; contents are don't-care until written, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= shreg;
      end
   end

   // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a set in the same cycle as clr_err takes priority.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overrun     <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         overrun     <= (push_req & full & ~pop) | (overrun & ~clr_err);
         frame_error <= ferr_set | (frame_error & ~clr_err);
      end
   end

   assign data_valid = ~empty;
   assign rdata      = empty ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at default parameters (10 clocks per bit, 4-entry FIFO).
// Directed table of frames, hand-written corner sequences, then random frames against a queue model.
// Outputs are sampled #1 after the rising edge (directed) or on the falling edge (random phase).
module tb_uart_receiver;

   logic       clk = 1'b0;
   logic       resetn;
   logic       rxd;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rdata;
   logic       data_valid;
   logic       overrun;
   logic       frame_error;

   uart_receiver dut (
      .clk         (clk),
      .resetn      (resetn),
      .rxd         (rxd),
      .rd_en       (rd_en),
      .clr_err     (clr_err),
      .rdata       (rdata),
      .data_valid  (data_valid),
      .overrun     (overrun),
      .frame_error (frame_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         at;
      logic [7:0] d;
   } push_t;

   typedef struct {
      logic [7:0] data;
      bit         stop_low;
      logic       exp_dv;
      logic [7:0] exp_rdata;
      logic       exp_ferr;
   } vec_t;

   push_t      sched[$];
   logic [7:0] mq[$];
   logic       mov;
   int         rd_prob;
   bit         rand_done;
   int         last_fall;
   int         dv_rise;
   logic       dv_q = 1'b0;
   vec_t       vecs[6];
   int         k0;
   bit         full_m, pop_m, push_m, set_ov;
   logic [7:0] pd;
   push_t      ph;

   // Record the cycle in which data_valid rises.
   always @(negedge clk) begin
      if (data_valid && !dv_q) dv_rise = cyc;
      dv_q = data_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time budget exceeded, got no summary, required completion");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame, one bit per 10 clocks. The stop region lasts stop_len clocks
   // (held low when stop_low). trunc>0 cuts the frame short. When pop_on_push is set, rd_en
   // is raised so it is sampled on the stop-sample edge: 2 sync + 1 edge detect + 5 half bit
   // + 80 data + 10 stop = 98 edges after the falling edge was driven.
   task automatic send_frame(input logic [7:0] b, input int stop_len, input bit stop_low,
                             input bit pop_on_push, input int trunc, input bit sched_it);
      int total;
      total = 90 + stop_len;
      if (trunc > 0 && trunc < total) total = trunc;
      for (int c = 0; c < total; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) begin
            last_fall = cyc;
            if (sched_it && !stop_low) sched.push_back('{cyc + 98, b});
         end
         if (c < 10)      rxd = 1'b0;
         else if (c < 90) rxd = b[3'((c - 10) / 10)];
         else             rxd = ~stop_low;
         if (pop_on_push) rd_en = (c == 97);
      end
      if (stop_low) begin
         @(posedge clk);
         #1;
         rxd = 1'b1;
      end
   endtask

   task automatic pop_chk(input string name, input logic [7:0] exp);
      chk({name, "_valid"}, 32'(data_valid), 32'(1'b1));
      chk({name, "_rdata"}, 32'(rdata), 32'(exp));
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0};
      vecs[2] = '{8'h96, 1'b0, 1'b1, 8'h96, 1'b0};
      vecs[3] = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
      vecs[5] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0};

      resetn  = 1'b0;
      rxd     = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      mov     = 1'b0;
      rd_prob = 0;
      rand_done = 1'b0;

      // Reset state
      idle(3);
      chk("rst_valid", 32'(data_valid), 32'(1'b0));
      chk("rst_rdata", 32'(rdata), 32'(8'h00));
      chk("rst_overrun", 32'(overrun), 32'(1'b0));
      chk("rst_ferr", 32'(frame_error), 32'(1'b0));
      resetn = 1'b1;
      idle(5);

      // Single byte, latency to data_valid, then one pop empties the FIFO
      dv_rise = -1;
      idle(1);
      send_frame(8'h55, 10, 1'b0, 1'b0, 0, 1'b0);
      k0 = last_fall;
      chk("lat_rise_cycle", 32'(dv_rise), 32'(k0 + 98));
      pop_chk("lat", 8'h55);
      chk("lat_empty", 32'(data_valid), 32'(1'b0));

      // Table of frames, including a low stop bit followed by a good frame
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].stop_low ? 30 : 10, vecs[i].stop_low, 1'b0, 0, 1'b0);
         idle(20);
         chk("tbl_valid", 32'(data_valid), 32'(vecs[i].exp_dv));
         if (vecs[i].exp_dv) chk("tbl_rdata", 32'(rdata), 32'(vecs[i].exp_rdata));
         chk("tbl_ferr", 32'(frame_error), 32'(vecs[i].exp_ferr));
         if (data_valid) begin
            rd_en = 1'b1;
            idle(1);
            rd_en = 1'b0;
         end
         pulse_clr();
         chk("tbl_ferr_clr", 32'(frame_error), 32'(1'b0));
      end

      // Short low glitch on an idle line
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         rxd = 1'b0;
      end
      rxd = 1'b1;
      idle(200);
      chk("glitch_valid", 32'(data_valid), 32'(1'b0));
      chk("glitch_overrun", 32'(overrun), 32'(1'b0));
      chk("glitch_ferr", 32'(frame_error), 32'(1'b0));

      // Five back-to-back frames without reads: fifth is dropped
      for (int i = 0; i < 5; i++) send_frame(8'h41 + 8'(i), 10, 1'b0, 1'b0, 0, 1'b0);
      idle(1);
      chk("ovr_set", 32'(overrun), 32'(1'b1));
      for (int i = 0; i < 4; i++) pop_chk("ovr_pop", 8'h41 + 8'(i));
      chk("ovr_empty", 32'(data_valid), 32'(1'b0));
      chk("ovr_ferr", 32'(frame_error), 32'(1'b0));
      pulse_clr();
      chk("ovr_clr", 32'(overrun), 32'(1'b0));

      // Full FIFO, pop on the same edge as the fifth push
      for (int i = 0; i < 4; i++) send_frame(8'hD1 + 8'(i), 10, 1'b0, 1'b0, 0, 1'b0);
      send_frame(8'hD5, 10, 1'b0, 1'b1, 0, 1'b0);
      idle(2);
      chk("fullpp_overrun", 32'(overrun), 32'(1'b0));
      for (int i = 0; i < 4; i++) pop_chk("fullpp_pop", 8'hD2 + 8'(i));
      chk("fullpp_empty", 32'(data_valid), 32'(1'b0));

      // Reset in the middle of a frame's data bits
      send_frame(8'h11, 10, 1'b0, 1'b0, 0, 1'b0);
      idle(2);
      chk("mid_pre_valid", 32'(data_valid), 32'(1'b1));
      send_frame(8'h99, 10, 1'b0, 1'b0, 40, 1'b0);
      resetn = 1'b0;
      rxd    = 1'b1;
      idle(2);
      chk("mid_rst_valid", 32'(data_valid), 32'(1'b0));
      chk("mid_rst_rdata", 32'(rdata), 32'(8'h00));
      chk("mid_rst_overrun", 32'(overrun), 32'(1'b0));
      chk("mid_rst_ferr", 32'(frame_error), 32'(1'b0));
      resetn = 1'b1;
      idle(20);
      send_frame(8'h7E, 10, 1'b0, 1'b0, 0, 1'b0);
      idle(3);
      chk("mid_ferr", 32'(frame_error), 32'(1'b0));
      pop_chk("mid_7e", 8'h7E);
      chk("mid_empty", 32'(data_valid), 32'(1'b0));

      // Random frames and random reads/clears against a queue model of the FIFO
      resetn = 1'b0;
      idle(2);
      resetn = 1'b1;
      idle(3);
      mq.delete();
      sched.delete();
      mov = 1'b0;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               rd_prob = ($urandom_range(0, 2) == 0) ? 4 : 0;
               send_frame(8'($urandom_range(0, 255)), 10, 1'b0, 1'b0, 0, 1'b1);
               idle($urandom_range(0, 3));
            end
            idle(120);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clk);
               chk("rnd_valid", 32'(data_valid), 32'(mq.size() > 0));
               if (mq.size() > 0) chk("rnd_rdata", 32'(rdata), 32'(mq[0]));
               chk("rnd_overrun", 32'(overrun), 32'(mov));
               chk("rnd_ferr", 32'(frame_error), 32'(1'b0));
               rd_en   = ($urandom_range(0, 99) < rd_prob);
               clr_err = ($urandom_range(0, 99) < 1);
               full_m = (mq.size() == 4);
               pop_m  = rd_en && (mq.size() > 0);
               push_m = 1'b0;
               set_ov = 1'b0;
               pd     = 8'h00;
               if (sched.size() > 0 && sched[0].at == cyc + 1) begin
                  ph     = sched.pop_front();
                  push_m = 1'b1;
                  pd     = ph.d;
               end
               if (pop_m) void'(mq.pop_front());
               if (push_m) begin
                  if (full_m && !pop_m) set_ov = 1'b1;
                  else mq.push_back(pd);
               end
               mov = set_ov ? 1'b1 : (clr_err ? 1'b0 : mov);
            end
            rd_en   = 1'b0;
            clr_err = 1'b0;
         end
      join
      chk("rnd_sched_drained", 32'(sched.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
